// File: rtl/save_unpack_if.sv
// Beat stream from save_unpack to the AXI write master; one beat per tvalid & tready.
// Zero latency, pure wires; the slave backpressures the master through tready.
interface save_unpack_if #(
    parameter int DW = 512
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/save_unpack.sv
// Write-back unpacker: buffer lines -> 16 beats each -> write-master stream; SAVE_PREFETCH_EN adds a second line register.
// Line 0 costs BUF_RD_LATENCY+1 fill cycles; beats advance only on tvalid & tready, everything else holds under stall.
module save_unpack #(
    parameter int SAVE_INST_LENGTH   = 128,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int BUF_RD_LATENCY     = 1
) (
    input  logic                               kernel_clk,
    input  logic                               kernel_rst_n,
    input  logic                               ap_start,
    output logic                               ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [SAVE_INST_LENGTH-1:0]        ctrl_instruction,
    output logic                               save_read_buffer_r_en,
    output logic [12:0]                        save_read_buffer_r_addr,
    input  logic [16*C_M_AXI_DATA_WIDTH-1:0]   save_read_buffer_r_data,
    output logic                               wr_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      wr_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]       wr_xfer_size_in_bytes,
    input  logic                               wr_done,
    save_unpack_if.master                      m_axis
);
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int LW = 16 * DW;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int XW = C_XFER_SIZE_WIDTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_FILL    = 3'd3;
    localparam logic [2:0] S_STREAM  = 3'd4;
    localparam logic [2:0] S_WAIT_WR = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]                state;
    logic [12:0]               buf_start;
    logic [15:0]               line_cnt;
    logic [15:0]               line_idx;
    logic [15:0]               rd_idx;
    logic [15:0]               xfer_bytes;
    logic [31:0]               dram_addr;
    logic [AW-1:0]             addr_off;
    logic [3:0]                beat;
    logic                      wr_seen;
    logic [LW-1:0]             cur_line;
    logic [BUF_RD_LATENCY-1:0] rd_pipe;

    logic hs;
    logic last_beat;
    logic last_line;
    logic line_end;
    logic cap;
    logic rd_next;
    logic inst_unused;

`ifdef SAVE_PREFETCH_EN
    logic [LW-1:0] nxt_line;
    logic          nxt_vld;
    logic          issue_pend;
`endif

    assign inst_unused = ^{ctrl_instruction[79:64], ctrl_instruction[47:45], ctrl_instruction[31:0]};

    assign m_axis.tvalid = (state == S_STREAM);
    assign m_axis.tdata  = m_axis.tvalid ? cur_line[int'(beat) * DW +: DW] : '0;
    assign m_axis.tlast  = m_axis.tvalid && last_beat && last_line;

    assign hs        = m_axis.tvalid && m_axis.tready;
    assign last_beat = (beat == 4'hF);
    assign last_line = (line_idx == line_cnt - 16'd1);
    assign line_end  = hs && last_beat;
    assign cap       = rd_pipe[BUF_RD_LATENCY-1];

    // Prefetch reads the next line right after a capture; otherwise only once the current line drains.
`ifdef SAVE_PREFETCH_EN
    assign rd_next = (state == S_STREAM) && issue_pend;
`else
    assign rd_next = line_end && !last_line;
`endif

    assign save_read_buffer_r_en   = (state == S_ISSUE) || rd_next;
    assign save_read_buffer_r_addr = (state == S_ISSUE) ? buf_start : buf_start + rd_idx[12:0];

    assign wr_start              = (state == S_ISSUE);
    assign wr_addr_offset        = addr_off + AW'(dram_addr);
    assign wr_xfer_size_in_bytes = XW'(xfer_bytes);
    assign ap_done               = (state == S_DONE);

    generate
        if (BUF_RD_LATENCY == 1) begin : g_pipe1
            always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
                if (!kernel_rst_n) rd_pipe <= '0;
                else               rd_pipe <= save_read_buffer_r_en;
            end
        end else begin : g_pipen
            always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
                if (!kernel_rst_n) rd_pipe <= '0;
                else               rd_pipe <= {rd_pipe[BUF_RD_LATENCY-2:0], save_read_buffer_r_en};
            end
        end
    endgenerate

    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            state      <= S_IDLE;
            buf_start  <= '0;
            line_cnt   <= '0;
            line_idx   <= '0;
            rd_idx     <= '0;
            xfer_bytes <= '0;
            dram_addr  <= '0;
            addr_off   <= '0;
            beat       <= '0;
            wr_seen    <= 1'b0;
            cur_line   <= '0;
`ifdef SAVE_PREFETCH_EN
            nxt_line   <= '0;
            nxt_vld    <= 1'b0;
            issue_pend <= 1'b0;
`endif
        end else begin
            if (state == S_ISSUE) rd_idx <= 16'd1;
            else if (rd_next)     rd_idx <= rd_idx + 16'd1;

            // wr_done may beat the last handshake; remember it so WAIT_WR cannot miss it.
            if (wr_done && (state == S_FILL || state == S_STREAM || state == S_WAIT_WR))
                wr_seen <= 1'b1;

`ifdef SAVE_PREFETCH_EN
            if (rd_next) issue_pend <= 1'b0;
            if (cap && state != S_FILL) begin
                nxt_line <= save_read_buffer_r_data;
                nxt_vld  <= 1'b1;
            end
`endif

            case (state)
                S_IDLE: begin
                    wr_seen <= 1'b0;
                    if (ap_start) begin
                        buf_start  <= ctrl_instruction[44:32];
                        line_cnt   <= ctrl_instruction[63:48];
                        xfer_bytes <= ctrl_instruction[95:80];
                        dram_addr  <= ctrl_instruction[127:96];
                        addr_off   <= ctrl_addr_offset;
                        line_idx   <= '0;
                        beat       <= '0;
                        state      <= S_DECODE;
                    end
                end
                S_DECODE: state <= (line_cnt == 16'd0) ? S_DONE : S_ISSUE;
                S_ISSUE:  state <= S_FILL;
                S_FILL: begin
                    if (cap) begin
                        cur_line <= save_read_buffer_r_data;
                        state    <= S_STREAM;
`ifdef SAVE_PREFETCH_EN
                        issue_pend <= (rd_idx < line_cnt);
`endif
                    end
                end
                S_STREAM: begin
                    if (hs) begin
                        beat <= beat + 4'd1;
                        if (last_beat) begin
                            if (last_line) begin
                                state <= S_WAIT_WR;
                            end else begin
                                line_idx <= line_idx + 16'd1;
`ifdef SAVE_PREFETCH_EN
                                if (nxt_vld) begin
                                    cur_line   <= nxt_line;
                                    nxt_vld    <= 1'b0;
                                    issue_pend <= (rd_idx < line_cnt);
                                end else begin
                                    state <= S_FILL;
                                end
`else
                                state <= S_FILL;
`endif
                            end
                        end
                    end
                end
                S_WAIT_WR: if (wr_seen || wr_done) state <= S_DONE;
                S_DONE:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_save_unpack.sv
module tb_save_unpack;
    localparam int DW = 512;
    localparam int LW = 16 * DW;

    logic           kernel_clk = 1'b0;
    logic           kernel_rst_n = 1'b0;
    logic           ap_start = 1'b0;
    logic           ap_done;
    logic [63:0]    ctrl_addr_offset = '0;
    logic [127:0]   ctrl_instruction = '0;
    logic           r_en;
    logic [12:0]    r_addr;
    logic [LW-1:0]  r_data = '0;
    logic           wr_start;
    logic [63:0]    wr_addr_offset;
    logic [31:0]    wr_xfer_size_in_bytes;
    logic           wr_done = 1'b0;

    save_unpack_if #(.DW(DW)) axis ();

    always #5 kernel_clk = ~kernel_clk;

    save_unpack dut (
        .kernel_clk              (kernel_clk),
        .kernel_rst_n            (kernel_rst_n),
        .ap_start                (ap_start),
        .ap_done                 (ap_done),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_instruction        (ctrl_instruction),
        .save_read_buffer_r_en   (r_en),
        .save_read_buffer_r_addr (r_addr),
        .save_read_buffer_r_data (r_data),
        .wr_start                (wr_start),
        .wr_addr_offset          (wr_addr_offset),
        .wr_xfer_size_in_bytes   (wr_xfer_size_in_bytes),
        .wr_done                 (wr_done),
        .m_axis                  (axis)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [527:0] got, input logic [527:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_val(input logic [12:0] a, input int k);
        logic [DW-1:0] v;
        v       = '0;
        v[20:8] = a;
        v[7:0]  = 8'(k);
        return v;
    endfunction

    function automatic logic [LW-1:0] line_of(input logic [12:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < 16; k++) l[k*DW +: DW] = beat_val(a, k);
        return l;
    endfunction

    // Buffer model, one cycle read latency
    always @(posedge kernel_clk) if (r_en) r_data <= line_of(r_addr);

    // Ready driver: mode 0 always ready, mode 1 repeats 1,0,0,1
    int         rdy_mode = 0;
    int         rdy_ph   = 0;
    logic [3:0] rdy_pat  = 4'b1001;
    initial begin
        axis.tready = 1'b1;
        forever begin
            @(posedge kernel_clk);
            #1;
            rdy_ph++;
            axis.tready = (rdy_mode == 0) ? 1'b1 : rdy_pat[rdy_ph % 4];
        end
    end

    // Monitor
    int            cyc = 0;
    logic [DW-1:0] hs_dat[$];
    logic          hs_last[$];
    logic [12:0]   raddr_q[$];
    int n_wr_start, n_done, done_cyc, start_cyc, wrdone_cyc, hs_cyc_last;
    int tv_run, tv_run_max, tv_cycles, stall_viol;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat;
    logic          prev_last;

    always @(negedge kernel_clk) begin
        cyc++;
        if (ap_start) start_cyc = cyc;
        if (wr_done)  wrdone_cyc = cyc;
        if (ap_done) begin n_done++; done_cyc = cyc; end
        if (wr_start) n_wr_start++;
        if (r_en) raddr_q.push_back(r_addr);
        if (axis.tvalid) begin
            tv_cycles++;
            tv_run++;
            if (tv_run > tv_run_max) tv_run_max = tv_run;
        end else begin
            tv_run = 0;
        end
        if (prev_stall && (!axis.tvalid || axis.tdata !== prev_dat || axis.tlast !== prev_last))
            stall_viol++;
        prev_stall = axis.tvalid && !axis.tready;
        prev_dat   = axis.tdata;
        prev_last  = axis.tlast;
        if (axis.tvalid && axis.tready) begin
            hs_dat.push_back(axis.tdata);
            hs_last.push_back(axis.tlast);
            hs_cyc_last = cyc;
        end
    end

    task automatic clear_mon();
        hs_dat.delete();
        hs_last.delete();
        raddr_q.delete();
        n_wr_start = 0; n_done = 0; done_cyc = -100; start_cyc = -100; wrdone_cyc = -100;
        hs_cyc_last = -100; tv_run = 0; tv_run_max = 0; tv_cycles = 0; stall_viol = 0;
    endtask

    task automatic start_op(input logic [15:0] cnt, input logic [12:0] bufa, input logic [15:0] bytes,
                            input logic [31:0] dram, input logic [63:0] offs);
        @(posedge kernel_clk);
        #1;
        ctrl_addr_offset         = offs;
        ctrl_instruction         = '0;
        ctrl_instruction[47:32]  = {3'b000, bufa};
        ctrl_instruction[63:48]  = cnt;
        ctrl_instruction[95:80]  = bytes;
        ctrl_instruction[127:96] = dram;
        ap_start = 1'b1;
        @(posedge kernel_clk);
        #1;
        ap_start = 1'b0;
    endtask

    task automatic wait_hs(input int n, input int budget);
        int i = 0;
        while (hs_dat.size() < n && i < budget) begin
            @(posedge kernel_clk);
            i++;
        end
        if (hs_dat.size() < n) check("hs_timeout", hs_dat.size(), n);
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (n_done == 0 && i < budget) begin
            @(posedge kernel_clk);
            i++;
        end
        if (n_done == 0) check("done_timeout", 0, 1);
    endtask

    task automatic pulse_wr_done();
        @(posedge kernel_clk);
        #1;
        wr_done = 1'b1;
        @(posedge kernel_clk);
        #1;
        wr_done = 1'b0;
    endtask

    task automatic verify_beats(input string tag, input logic [12:0] base, input int cnt);
        logic [12:0] a;
        check({tag, "_count"}, hs_dat.size(), 16 * cnt);
        for (int i = 0; i < 16 * cnt; i++) begin
            if (i < hs_dat.size()) begin
                a = base + 13'(i / 16);
                check({tag, "_beat"}, {hs_last[i], hs_dat[i]}, {(i == 16 * cnt - 1), beat_val(a, i % 16)});
            end
        end
    endtask

    initial begin
        clear_mon();
        repeat (3) @(posedge kernel_clk);
        #2;
        check("rst_ap_done", ap_done, 0);
        check("rst_wr_start", wr_start, 0);
        check("rst_r_en", r_en, 0);
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tdata", axis.tdata, 0);
        check("rst_wr_addr", wr_addr_offset, 0);
        @(posedge kernel_clk);
        #1;
        kernel_rst_n = 1'b1;

        // T1: single line
        clear_mon();
        start_op(16'd1, 13'h0010, 16'd1024, 32'h0000_1000, 64'h1_0000_0000);
        wait_hs(16, 200);
        repeat (3) @(posedge kernel_clk);
        pulse_wr_done();
        wait_done(50);
        verify_beats("t1", 13'h0010, 1);
        check("t1_wr_start", n_wr_start, 1);
        check("t1_rd_count", raddr_q.size(), 1);
        if (raddr_q.size() > 0) check("t1_rd_addr", raddr_q[0], 13'h0010);
        check("t1_wr_addr", wr_addr_offset, 64'h1_0000_1000);
        check("t1_xfer", wr_xfer_size_in_bytes, 32'd1024);
        check("t1_done_lat", done_cyc - wrdone_cyc, 1);
        check("t1_done_cnt", n_done, 1);

        // T2: address wrap
        clear_mon();
        start_op(16'd3, 13'h1FFF, 16'd3072, 32'h0000_2000, 64'h0);
        wait_hs(48, 400);
        pulse_wr_done();
        wait_done(50);
        verify_beats("t2", 13'h1FFF, 3);
        check("t2_rd_count", raddr_q.size(), 3);
        if (raddr_q.size() == 3) begin
            check("t2_rd0", raddr_q[0], 13'h1FFF);
            check("t2_rd1", raddr_q[1], 13'h0000);
            check("t2_rd2", raddr_q[2], 13'h0001);
        end
`ifdef SAVE_PREFETCH_EN
        check("t2_tv_run", tv_run_max, 48);
`else
        check("t2_tv_run", tv_run_max, 16);
`endif

        // T3: backpressure
        clear_mon();
        rdy_mode = 1;
        start_op(16'd2, 13'h0100, 16'd2048, 32'h0000_4000, 64'h0);
        wait_hs(32, 600);
        pulse_wr_done();
        wait_done(50);
        rdy_mode = 0;
        verify_beats("t3", 13'h0100, 2);
        check("t3_stall_stable", stall_viol, 0);

        // T4: zero lines
        clear_mon();
        start_op(16'd0, 13'h0020, 16'd0, 32'h0, 64'h0);
        wait_done(20);
        check("t4_wr_start", n_wr_start, 0);
        check("t4_r_en", raddr_q.size(), 0);
        check("t4_tvalid", tv_cycles, 0);
        check("t4_done_lat", done_cyc - start_cyc, 2);

        // T5: early wr_done, dropped second ap_start
        clear_mon();
        start_op(16'd2, 13'h0200, 16'd2048, 32'h0000_3000, 64'h10);
        wait_hs(4, 100);
        start_op(16'd1, 13'h0700, 16'd1024, 32'h0000_9999, 64'h5555);
        wait_hs(20, 100);
        pulse_wr_done();
        wait_hs(32, 100);
        wait_done(50);
        verify_beats("t5", 13'h0200, 2);
        check("t5_done_lat", done_cyc - hs_cyc_last, 2);
        check("t5_wr_addr", wr_addr_offset, 64'h3010);
        repeat (40) @(posedge kernel_clk);
        check("t5_no_requeue_hs", hs_dat.size(), 32);
        check("t5_wr_start", n_wr_start, 1);
        check("t5_done_cnt", n_done, 1);

        // T6: reset mid-stream, then a clean run
        clear_mon();
        start_op(16'd2, 13'h0300, 16'd2048, 32'h0000_5000, 64'h0);
        wait_hs(23, 100);
        @(negedge kernel_clk);
        #2;
        kernel_rst_n = 1'b0;
        #1;
        check("t6_async_tvalid", axis.tvalid, 0);
        check("t6_async_tdata", axis.tdata, 0);
        check("t6_async_r_en", r_en, 0);
        repeat (3) @(posedge kernel_clk);
        #1;
        kernel_rst_n = 1'b1;
        repeat (5) @(posedge kernel_clk);
        check("t6_no_done", n_done, 0);
        clear_mon();
        start_op(16'd1, 13'h0400, 16'd1024, 32'h0000_6000, 64'h0);
        wait_hs(16, 200);
        pulse_wr_done();
        wait_done(50);
        verify_beats("t6b", 13'h0400, 1);
        check("t6b_done_cnt", n_done, 1);

`ifdef SAVE_PREFETCH_EN
        // T7: gapless streaming
        clear_mon();
        start_op(16'd4, 13'h0500, 16'd4096, 32'h0000_7000, 64'h0);
        wait_hs(64, 400);
        pulse_wr_done();
        wait_done(50);
        verify_beats("t7", 13'h0500, 4);
        check("t7_tv_run", tv_run_max, 64);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
